// File: rtl/fluxo_dados_rodadas.sv
// fluxo_dados_rodadas: parametrised datapath for the memory-sequence game
module fluxo_dados_rodadas #(
   parameter int NB              = 4,
   parameter int AW              = 4,
   parameter int TIMEOUT_FACIL   = 5000,
   parameter int TIMEOUT_DIFICIL = 3000,
   parameter int LIMITE_FACIL    = 7,
   parameter int LIMITE_DIFICIL  = 15
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          zeraE,
   input  logic          contaE,
   input  logic          zeraR,
   input  logic          contaR,
   input  logic          zeraT,
   input  logic          ativaT,
   input  logic          registraN,
   input  logic          nivel,
   input  logic          zeraJ,
   input  logic          registraJ,
   input  logic          escreveM,
   input  logic          zeraL,
   input  logic          registraL,
   input  logic [NB-1:0] botoes,
   output logic [NB-1:0] jogada,
   output logic [NB-1:0] leds,
   output logic          igual,
   output logic          tem_jogada,
   output logic          fimE,
   output logic          fimR,
   output logic          timeout,
   output logic          nivel_q,
   output logic [AW-1:0] db_endereco,
   output logic [AW-1:0] db_rodada
);

   localparam int TMAX = (TIMEOUT_FACIL > TIMEOUT_DIFICIL) ? TIMEOUT_FACIL : TIMEOUT_DIFICIL;
   localparam int TW   = $clog2(TMAX);
   localparam int PROF = 2 ** AW;
   localparam logic [TW-1:0] FIM_T_FACIL   = TW'(TIMEOUT_FACIL - 1);
   localparam logic [TW-1:0] FIM_T_DIFICIL = TW'(TIMEOUT_DIFICIL - 1);
   localparam logic [AW-1:0] LIM_FACIL     = AW'(LIMITE_FACIL);
   localparam logic [AW-1:0] LIM_DIFICIL   = AW'(LIMITE_DIFICIL);
   localparam logic [AW-1:0] R_MAX         = '1;

   if (NB < 1) begin : g_err_nb
      $error("fluxo_dados_rodadas: NB must be at least 1");
   end
   if (AW < 1 || AW > 16) begin : g_err_aw
      $error("fluxo_dados_rodadas: AW must be in 1..16");
   end
   if (TIMEOUT_FACIL < 2 || TIMEOUT_DIFICIL < 2) begin : g_err_timeout
      $error("fluxo_dados_rodadas: timeout periods must be at least 2 clocks");
   end
   if (LIMITE_FACIL < 0 || LIMITE_FACIL > PROF - 1) begin : g_err_lim_f
      $error("fluxo_dados_rodadas: LIMITE_FACIL out of range");
   end
   if (LIMITE_DIFICIL < 0 || LIMITE_DIFICIL > PROF - 1) begin : g_err_lim_d
      $error("fluxo_dados_rodadas: LIMITE_DIFICIL out of range");
   end

   logic [AW-1:0] e_cnt;
   logic [AW-1:0] r_cnt;
   logic [TW-1:0] t_cnt;
   logic          prev;
   logic [NB-1:0] mem [PROF];
   logic [NB-1:0] mem_e;

   // play-index counter, wraps at the top of the memory
   always_ff @(posedge clock or negedge reset)
      if (!reset) e_cnt <= '0;
      else if (zeraE) e_cnt <= '0;
      else if (contaE) e_cnt <= e_cnt + 1'b1;

   // round counter, saturates so it never wraps back to round 0
   always_ff @(posedge clock or negedge reset)
      if (!reset) r_cnt <= '0;
      else if (zeraR) r_cnt <= '0;
      else if (contaR && r_cnt != R_MAX) r_cnt <= r_cnt + 1'b1;

   // timer: >= makes a level change past the new period still fire on the next active edge
   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         t_cnt   <= '0;
         timeout <= 1'b0;
      end else if (zeraT) begin
         t_cnt   <= '0;
         timeout <= 1'b0;
      end else if (ativaT) begin
         if (t_cnt >= (nivel_q ? FIM_T_DIFICIL : FIM_T_FACIL)) timeout <= 1'b1;
         else t_cnt <= t_cnt + 1'b1;
      end

   // level register
   always_ff @(posedge clock or negedge reset)
      if (!reset) nivel_q <= 1'b0;
      else if (registraN) nivel_q <= nivel;

   // play register
   always_ff @(posedge clock or negedge reset)
      if (!reset) jogada <= '0;
      else if (zeraJ) jogada <= '0;
      else if (registraJ) jogada <= botoes;

   // LED register, loaded from the pre-write memory contents
   always_ff @(posedge clock or negedge reset)
      if (!reset) leds <= '0;
      else if (zeraL) leds <= '0;
      else if (registraL) leds <= mem_e;

   // sequence memory, cleared entirely by reset
   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         for (int i = 0; i < PROF; i++) mem[i] <= '0;
      end else if (escreveM) mem[e_cnt] <= jogada;

   // any-button history for rising-edge detection
   always_ff @(posedge clock or negedge reset)
      if (!reset) prev <= 1'b0;
      else prev <= |botoes;

   // combinational status derived from the registered state
   always_comb begin
      mem_e       = mem[e_cnt];
      igual       = (jogada == mem_e) && (|jogada);
      tem_jogada  = (|botoes) && !prev;
      fimE        = e_cnt == r_cnt;
      fimR        = r_cnt == (nivel_q ? LIM_DIFICIL : LIM_FACIL);
      db_endereco = e_cnt;
      db_rodada   = r_cnt;
   end

endmodule

// File: tb/tb_fluxo_dados_rodadas.sv
// tb_fluxo_dados_rodadas: directed and random checks against a behavioural game model
module tb_fluxo_dados_rodadas;

   localparam int TF = 5000, TD = 3000, LF = 7, LD = 15;

   logic clock = 1'b0;
   logic reset;
   logic zeraE, contaE, zeraR, contaR, zeraT, ativaT, registraN, nivel;
   logic zeraJ, registraJ, escreveM, zeraL, registraL;
   logic [3:0] botoes, jogada, leds, db_endereco, db_rodada;
   logic igual, tem_jogada, fimE, fimR, timeout, nivel_q;

   fluxo_dados_rodadas dut (
      .clock(clock), .reset(reset), .zeraE(zeraE), .contaE(contaE), .zeraR(zeraR),
      .contaR(contaR), .zeraT(zeraT), .ativaT(ativaT), .registraN(registraN),
      .nivel(nivel), .zeraJ(zeraJ), .registraJ(registraJ), .escreveM(escreveM),
      .zeraL(zeraL), .registraL(registraL), .botoes(botoes), .jogada(jogada),
      .leds(leds), .igual(igual), .tem_jogada(tem_jogada), .fimE(fimE), .fimR(fimR),
      .timeout(timeout), .nivel_q(nivel_q), .db_endereco(db_endereco), .db_rodada(db_rodada)
   );

   always #5 clock = ~clock;

   int vectors = 0, errors = 0;

   // behavioural game state: round/index as integers, elapsed active time, sequence array
   int m_e, m_r, m_el;
   bit m_to, m_nq, m_prev;
   logic [3:0] m_j, m_l;
   logic [3:0] m_mem [16];
   logic last_tj;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_e = 0; m_r = 0; m_el = 0; m_to = 0; m_nq = 0; m_prev = 0; m_j = 0; m_l = 0;
      for (int i = 0; i < 16; i++) m_mem[i] = 0;
   endtask

   task automatic idle();
      {zeraE, contaE, zeraR, contaR, zeraT, ativaT, registraN, nivel} = '0;
      {zeraJ, registraJ, escreveM, zeraL, registraL} = '0;
   endtask

   task automatic check_all();
      chk("jogada", jogada, m_j);
      chk("leds", leds, m_l);
      chk("igual", igual, (m_j == m_mem[m_e]) && (m_j != 0));
      chk("tem_jogada", tem_jogada, (botoes != 0) && !m_prev);
      chk("fimE", fimE, m_e == m_r);
      chk("fimR", fimR, m_r == (m_nq ? LD : LF));
      chk("timeout", timeout, m_to);
      chk("nivel_q", nivel_q, m_nq);
      chk("db_endereco", db_endereco, m_e);
      chk("db_rodada", db_rodada, m_r);
   endtask

   // one clock: check pre-edge outputs, predict the game state after the edge, then advance
   task automatic step();
      int ne, nr, nel;
      bit nto;
      logic [3:0] nl;
      #1;
      check_all();
      last_tj = tem_jogada;
      ne = zeraE ? 0 : contaE ? (m_e + 1) % 16 : m_e;
      nr = zeraR ? 0 : contaR ? ((m_r == 15) ? 15 : m_r + 1) : m_r;
      nel = zeraT ? 0 : m_el + (ativaT ? 1 : 0);
      nto = zeraT ? 0 : (m_to || (ativaT && nel >= (m_nq ? TD : TF)));
      nl = zeraL ? 4'd0 : registraL ? m_mem[m_e] : m_l;
      if (escreveM) m_mem[m_e] = m_j;
      @(posedge clock);
      #1;
      m_j = zeraJ ? 4'd0 : registraJ ? botoes : m_j;
      m_nq = registraN ? nivel : m_nq;
      m_prev = botoes != 0;
      m_e = ne; m_r = nr; m_el = nel; m_to = nto; m_l = nl;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      int n, pulses;
      idle();
      botoes = 0;
      reset = 1'b0;
      model_reset();
      #1;
      chk("reset_leds", leds, 0);
      chk("reset_jogada", jogada, 0);
      chk("reset_timeout", timeout, 0);
      @(posedge clock);
      #1;
      reset = 1'b1;

      // every memory entry reads back zero through the LED register
      registraL = 1; contaE = 1;
      for (int i = 0; i < 16; i++) begin
         step();
         chk("mem_zero", leds, 0);
      end
      idle();

      // write 0100 at E=3 and compare against several plays
      zeraE = 1; step(); idle();
      contaE = 1; steps(3); idle();
      botoes = 4'b0100; registraJ = 1; step(); idle();
      botoes = 0; escreveM = 1; step(); idle();
      step();
      chk("igual_hit", igual, 1);
      botoes = 4'b0010; registraJ = 1; step(); idle(); botoes = 0;
      step();
      chk("igual_other", igual, 0);
      zeraJ = 1; step(); idle();
      step();
      chk("igual_zero", igual, 0);

      // clears win over count/load
      zeraE = 1; contaE = 1; step(); idle();
      chk("prio_E", db_endereco, 0);
      contaE = 1; steps(3); idle();
      registraL = 1; step(); idle();
      chk("leds_load", leds, 4'b0100);
      zeraL = 1; registraL = 1; step(); idle();
      chk("prio_L", leds, 0);

      // simultaneous load/write/count events
      botoes = 4'b1000; registraJ = 1; step();
      botoes = 4'b0001; registraJ = 1; escreveM = 1; registraL = 1; contaE = 1; step(); idle();
      botoes = 0; steps(2);

      // rising-edge detector on the button OR
      pulses = 0;
      botoes = 4'b0001;
      for (int i = 0; i < 10; i++) begin step(); pulses += int'(last_tj); end
      chk("edge_one_pulse", pulses, 1);
      pulses = 0;
      botoes = 4'b0011;
      for (int i = 0; i < 5; i++) begin step(); pulses += int'(last_tj); end
      chk("edge_no_pulse", pulses, 0);
      botoes = 0; step();

      // rounds and limits per level
      zeraE = 1; zeraR = 1; registraN = 1; nivel = 0; step(); idle();
      contaR = 1; steps(7); idle();
      step();
      chk("fimR_facil", fimR, 1);
      chk("rodada_7", db_rodada, 7);
      contaE = 1; steps(7); idle();
      step();
      chk("fimE_7", fimE, 1);
      registraN = 1; nivel = 1; step(); idle();
      step();
      chk("fimR_dificil_low", fimR, 0);
      contaR = 1; steps(8); idle();
      step();
      chk("fimR_dificil", fimR, 1);
      contaR = 1; steps(3); idle();
      step();
      chk("rodada_sat", db_rodada, 15);

      // timeout at level 1, then level 0
      zeraT = 1; step(); idle();
      ativaT = 1;
      n = 0;
      while (!timeout && n < 6000) begin step(); n++; end
      chk("timeout_dificil_edges", n, TD);
      steps(5);
      chk("timeout_sticky", timeout, 1);
      idle(); zeraT = 1; step(); idle();
      chk("timeout_clear", timeout, 0);
      registraN = 1; nivel = 0; zeraT = 1; step(); idle();
      ativaT = 1;
      n = 0;
      while (!timeout && n < 8000) begin step(); n++; end
      chk("timeout_facil_edges", n, TF);
      idle(); zeraT = 1; step(); idle();

      // random control traffic with one asynchronous reset in the middle
      for (int i = 0; i < 1500; i++) begin
         zeraE = ($urandom % 10) == 0;   contaE = ($urandom % 3) == 0;
         zeraR = ($urandom % 20) == 0;   contaR = ($urandom % 4) == 0;
         zeraT = ($urandom % 50) == 0;   ativaT = ($urandom % 2) == 0;
         registraN = ($urandom % 15) == 0; nivel = 1'($urandom);
         zeraJ = ($urandom % 10) == 0;   registraJ = ($urandom % 3) == 0;
         escreveM = ($urandom % 3) == 0; zeraL = ($urandom % 10) == 0;
         registraL = ($urandom % 3) == 0; botoes = 4'($urandom);
         step();
         if (i == 700) begin
            botoes = 0;
            reset = 1'b0;
            model_reset();
            #1;
            check_all();
            chk("async_leds", leds, 0);
            chk("async_rodada", db_rodada, 0);
            reset = 1'b1;
         end
      end
      idle(); botoes = 0; step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
